hls_deadlock_monitor_param: RTL and testbench
=============================================

Name: hls_deadlock_monitor_param

Overview:
- Parametrised successor of the per-instance HLS deadlock monitor.
- Watches N_AXIS AXI-Stream block signals and N_INST sub-instance idle/block pairs, and raises `block` once a blocking condition has persisted for HOLD_CYCLES consecutive cycles.
- Optionally sticky until software clear; captures the first-blocking channel index and a saturating block-duration counter for debug readback.
- One instance sits per HLS top or sub-instance; its `block` feeds the parent monitor's inst_block_sigs.

Parameters:
- N_AXIS, 2, number of AXIS channels monitored (1..32)
- N_INST, 1, number of sub-instances monitored (0..16; 0 disables sub-instance aggregation)
- CHAN_DIR, 2'b10, per-channel direction bit: 0 = input stream (info code 2'b10), 1 = output stream (info code 2'b01)
- HOLD_CYCLES, 1, consecutive candidate cycles required before `block` asserts (>=1; 1 gives legacy one-cycle-latency behaviour)
- STICKY, 0, 1 = `block` and info are held until `clear`
- CNT_W, 16, width of the block-duration counter
- IDX_W, $clog2(N_AXIS+1), width of first_idx

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- axis_block_sigs  in  N_AXIS  per-channel blocked (stream stalled) flag
- inst_idle_sigs  in  max(N_INST,1)  sub-instance idle
- inst_block_sigs  in  max(N_INST,1)  sub-instance blocked
- clear  in  1  single-cycle clear of sticky state and counters
- axis_block_info  out  2*N_AXIS  per-channel 2-bit code; all-zero while block=0
- block  out  1  deadlock detected
- first_idx  out  IDX_W  lowest axis index blocked at assertion; N_AXIS when the cause was sub-instances only
- block_cycles  out  CNT_W  cycles `block` has been high, saturating

Behaviour:
- Reset (reset=0, async): all registers 0. Outputs are block=0, info=0, first_idx=0, block_cycles=0, state=IDLE, run=0.
- inst_all = (|inst_block_sigs) & &(inst_block_sigs | inst_idle_sigs). Every sub-instance is blocked or idle, and at least one is blocked. Forced to 0 when N_INST=0.
- cand = (|axis_block_sigs) | inst_all.
- Run counter `run`, width $clog2(HOLD_CYCLES+1):
  - cand=1: increments, saturating at HOLD_CYCLES.
  - cand=0: returns to 0.
  - trig = cand & (run+1 >= HOLD_CYCLES).
- FSM states, IDLE / SUSPECT / BLOCKED / LATCHED:
  - IDLE: trig -> BLOCKED; else cand -> SUSPECT.
  - SUSPECT: !cand -> IDLE; trig -> BLOCKED.
  - BLOCKED: !cand -> IDLE when STICKY=0, LATCHED when STICKY=1; else stay.
  - LATCHED: stays until clear. If cand is 1 in the clear cycle -> SUSPECT; otherwise -> IDLE.
- block is registered: 1 in BLOCKED and LATCHED. Latency: block rises exactly HOLD_CYCLES cycles after the first cand cycle.
- Info register:
  - Each cycle, info[2i+1:2i] <= axis_block_sigs[i] ? (CHAN_DIR[i] ? 2'b01 : 2'b10) : 2'b00.
  - Frozen in LATCHED.
  - Output gated to 0 when block=0.
- first_idx: loaded on the IDLE/SUSPECT->BLOCKED transition with the lowest set index of axis_block_sigs, or N_AXIS if none is set. Held otherwise.
- block_cycles:
  - Loaded with 1 on entering BLOCKED.
  - Increments each cycle while block=1, saturating at 2^CNT_W-1.
  - Held in IDLE/SUSPECT.
- Clear:
  - Zeroes run, block_cycles and first_idx and exits LATCHED.
  - In IDLE/SUSPECT/BLOCKED with STICKY=0: forces IDLE and run=0. Re-detection then restarts from the next cycle.
  - Clear wins over a simultaneous trig.
- Reset asserted mid-detection returns everything to IDLE immediately; no stale info survives.

Decomposition:
- Shared package hls_monitor_pkg:
  - state enum.
  - INFO_IN=2'b10, INFO_OUT=2'b01.
  - Function lowest_set_idx(vector, N).
- Sub-module hls_monitor_priority_enc (N-bit lowest-set-index encoder, returns N when empty) is used for first_idx.
- Channel info generation stays inline as a generate loop.

Test Plan:
1. Defaults (N_AXIS=2, HOLD=1, STICKY=0), axis_block_sigs=2'b10 for 3 cycles -> block=1 one cycle later for 3 cycles, info=4'b0100, first_idx=1, block_cycles counts 1,2,3, then block=0 and info=0.
2. HOLD_CYCLES=4, cand high 3 cycles then low, then high 5 cycles -> no block on the first burst; block rises on the 4th cycle edge of the second burst.
3. N_INST=3, inst_block=3'b001, inst_idle=3'b110 -> block=1 and first_idx=N_AXIS. With inst_idle=3'b010 instead -> block stays 0.
4. STICKY=1, channel 0 blocks 2 cycles then clears -> block stays 1 (LATCHED), info frozen at 2'b10, block_cycles keeps counting. clear pulse -> block=0 next cycle.
5. CNT_W=4, block held 20 cycles -> block_cycles saturates at 15.
6. reset pulled low mid-SUSPECT and mid-LATCHED -> all outputs 0 asynchronously. After release, stimulus from scenario 1 reproduces the same response.

Source files
------------

// File: rtl/hls_monitor_pkg.sv
// Shared definitions for the HLS deadlock monitor family.
//   mon_state_e    : detection FSM states
//   INFO_IN/OUT    : per-channel info codes for input / output streams
//   lowest_set_idx : index of the lowest set bit of vec[n-1:0], or n if none
package hls_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_BLOCKED = 2'd2,
    ST_LATCHED = 2'd3
  } mon_state_e;

  localparam logic [1:0] INFO_IN  = 2'b10;
  localparam logic [1:0] INFO_OUT = 2'b01;

  // Widest channel vector the monitor supports.
  localparam int MAX_CHANNELS = 32;

  function automatic int lowest_set_idx(input logic [MAX_CHANNELS-1:0] vec,
                                        input int n);
    int idx;
    idx = n;
    // Scan downwards so the last hit is the lowest index.
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if ((i < n) && vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hls_monitor_priority_enc.sv
// Lowest-set-index encoder.
//   vec : N-bit request vector
//   idx : index of the lowest set bit, N when vec is all-zero
module hls_monitor_priority_enc
  import hls_monitor_pkg::*;
#(
  parameter int N = 2,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx
);

  logic [MAX_CHANNELS-1:0] vec_ext;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    vec_ext        = '0;
    vec_ext[N-1:0] = vec;
    idx            = W'(lowest_set_idx(vec_ext, N));
  end

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Parametrised HLS deadlock monitor.
// Raises `block` once any AXIS channel is stalled, or every sub-instance is
// idle/blocked with at least one blocked, for HOLD_CYCLES consecutive cycles.
//   clock, reset (async, active-low)
//   axis_block_sigs  : per-channel stalled flag
//   inst_idle_sigs   : sub-instance idle flags
//   inst_block_sigs  : sub-instance blocked flags
//   clear            : single-cycle clear of sticky state and counters
//   axis_block_info  : 2-bit code per channel, zero while block=0
//   block            : deadlock detected (registered)
//   first_idx        : lowest blocked channel at assertion, N_AXIS if inst-only
//   block_cycles     : saturating count of cycles block has been high
module hls_deadlock_monitor_param
  import hls_monitor_pkg::*;
#(
  parameter int                N_AXIS      = 2,
  parameter int                N_INST      = 1,
  parameter logic [N_AXIS-1:0] CHAN_DIR    = N_AXIS'(2'b10),
  parameter int                HOLD_CYCLES = 1,
  parameter bit                STICKY      = 1'b0,
  parameter int                CNT_W       = 16,
  parameter int                IDX_W       = $clog2(N_AXIS + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_AXIS-1:0]                   axis_block_sigs,
  input  logic [((N_INST > 0) ? N_INST : 1)-1:0] inst_idle_sigs,
  input  logic [((N_INST > 0) ? N_INST : 1)-1:0] inst_block_sigs,
  input  logic                                clear,
  output logic [2*N_AXIS-1:0]                 axis_block_info,
  output logic                                block,
  output logic [IDX_W-1:0]                    first_idx,
  output logic [CNT_W-1:0]                    block_cycles
);

  localparam int RUN_W = $clog2(HOLD_CYCLES + 1);

  mon_state_e         state_q, state_nxt;
  logic [RUN_W-1:0]   run_q;
  logic               inst_all, cand, trig, run_sat;
  logic               block_q, block_nxt, enter_blocked, info_load;
  logic [2*N_AXIS-1:0] info_d, info_q;
  logic [IDX_W-1:0]   pe_idx, first_idx_q;
  logic [CNT_W-1:0]   cycles_q;

  // ---------------------------------------------------------------- candidate
  if (N_INST > 0) begin : g_inst
    assign inst_all = (|inst_block_sigs) & (&(inst_block_sigs | inst_idle_sigs));
  end else begin : g_no_inst
    assign inst_all = 1'b0;
  end

  assign cand    = (|axis_block_sigs) | inst_all;
  assign run_sat = (int'(run_q) >= HOLD_CYCLES);
  // The current candidate cycle counts towards the hold, hence run+1.
  assign trig    = cand & ((int'(run_q) + 1) >= HOLD_CYCLES);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)               run_q <= '0;
    else if (clear || !cand)  run_q <= '0;
    else if (!run_sat)        run_q <= run_q + RUN_W'(1);
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (clear) begin
      // Clear beats a simultaneous trigger; a live candidate while leaving
      // LATCHED resumes suspicion instead of dropping to idle.
      state_nxt = ((state_q == ST_LATCHED) && cand) ? ST_SUSPECT : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (trig) state_nxt = ST_BLOCKED;
                    else if (cand) state_nxt = ST_SUSPECT;
        ST_SUSPECT: if (!cand) state_nxt = ST_IDLE;
                    else if (trig) state_nxt = ST_BLOCKED;
        ST_BLOCKED: if (!cand) state_nxt = STICKY ? ST_LATCHED : ST_IDLE;
        ST_LATCHED: state_nxt = ST_LATCHED;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    block_nxt     = (state_nxt == ST_BLOCKED) || (state_nxt == ST_LATCHED);
    enter_blocked = (state_nxt == ST_BLOCKED) &&
                    ((state_q == ST_IDLE) || (state_q == ST_SUSPECT));
    // Freezing also covers the entry edge into LATCHED: the inputs in that
    // cycle are already quiet and would wipe the evidence.
    info_load     = (state_nxt != ST_LATCHED);
  end

  // ---------------------------------------------------------------- datapath
  for (genvar i = 0; i < N_AXIS; i++) begin : g_info
    assign info_d[2*i +: 2] = axis_block_sigs[i] ? (CHAN_DIR[i] ? INFO_OUT : INFO_IN)
                                                 : 2'b00;
  end

  hls_monitor_priority_enc #(
    .N (N_AXIS),
    .W (IDX_W)
  ) u_first_enc (
    .vec (axis_block_sigs),
    .idx (pe_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      block_q     <= 1'b0;
      info_q      <= '0;
      first_idx_q <= '0;
      cycles_q    <= '0;
    end else begin
      block_q <= block_nxt;
      if (info_load) info_q <= info_d;

      if (clear)              first_idx_q <= '0;
      else if (enter_blocked) first_idx_q <= pe_idx;

      // Counts cycles with block high: 1 on the rising edge, then +1 for
      // every further cycle block stays high.
      if (clear)                                    cycles_q <= '0;
      else if (enter_blocked)                       cycles_q <= CNT_W'(1);
      else if (block_q && block_nxt && (cycles_q != '1)) cycles_q <= cycles_q + CNT_W'(1);
    end
  end

  assign block           = block_q;
  assign axis_block_info = block_q ? info_q : '0;
  assign first_idx       = first_idx_q;
  assign block_cycles    = cycles_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Scoreboard bench for hls_deadlock_monitor_param. Four instances cover the
// default, long-hold, sub-instance and sticky/narrow-counter configurations.
module tb_hls_deadlock_monitor_param;

  logic clock, reset;

  // A: defaults
  logic [1:0]  a_axis;  logic [0:0] a_idle, a_iblk; logic a_clear;
  logic [3:0]  a_info;  logic a_block; logic [1:0] a_idx; logic [15:0] a_cyc;
  // B: HOLD_CYCLES=4
  logic [1:0]  b_axis;  logic [0:0] b_idle, b_iblk; logic b_clear;
  logic [3:0]  b_info;  logic b_block; logic [1:0] b_idx; logic [15:0] b_cyc;
  // C: N_INST=3
  logic [1:0]  c_axis;  logic [2:0] c_idle, c_iblk; logic c_clear;
  logic [3:0]  c_info;  logic c_block; logic [1:0] c_idx; logic [15:0] c_cyc;
  // D: STICKY=1, CNT_W=4
  logic [1:0]  d_axis;  logic [0:0] d_idle, d_iblk; logic d_clear;
  logic [3:0]  d_info;  logic d_block; logic [1:0] d_idx; logic [3:0] d_cyc;

  hls_deadlock_monitor_param #(.N_AXIS(2), .N_INST(1), .CHAN_DIR(2'b10), .HOLD_CYCLES(1),
    .STICKY(1'b0), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .axis_block_sigs(a_axis), .inst_idle_sigs(a_idle),
    .inst_block_sigs(a_iblk), .clear(a_clear), .axis_block_info(a_info), .block(a_block),
    .first_idx(a_idx), .block_cycles(a_cyc));

  hls_deadlock_monitor_param #(.N_AXIS(2), .N_INST(1), .CHAN_DIR(2'b10), .HOLD_CYCLES(4),
    .STICKY(1'b0), .CNT_W(16)) dut_b (
    .clock(clock), .reset(reset), .axis_block_sigs(b_axis), .inst_idle_sigs(b_idle),
    .inst_block_sigs(b_iblk), .clear(b_clear), .axis_block_info(b_info), .block(b_block),
    .first_idx(b_idx), .block_cycles(b_cyc));

  hls_deadlock_monitor_param #(.N_AXIS(2), .N_INST(3), .CHAN_DIR(2'b10), .HOLD_CYCLES(1),
    .STICKY(1'b0), .CNT_W(16)) dut_c (
    .clock(clock), .reset(reset), .axis_block_sigs(c_axis), .inst_idle_sigs(c_idle),
    .inst_block_sigs(c_iblk), .clear(c_clear), .axis_block_info(c_info), .block(c_block),
    .first_idx(c_idx), .block_cycles(c_cyc));

  hls_deadlock_monitor_param #(.N_AXIS(2), .N_INST(1), .CHAN_DIR(2'b10), .HOLD_CYCLES(1),
    .STICKY(1'b1), .CNT_W(4)) dut_d (
    .clock(clock), .reset(reset), .axis_block_sigs(d_axis), .inst_idle_sigs(d_idle),
    .inst_block_sigs(d_iblk), .clear(d_clear), .axis_block_info(d_info), .block(d_block),
    .first_idx(d_idx), .block_cycles(d_cyc));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int          dut;
    logic        blk;
    logic [31:0] info;
    logic [31:0] idx;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e, input logic blk, input logic [31:0] info,
                         input logic [31:0] idx, input logic [31:0] cyc);
    check({e.tag, ".block"},        {31'b0, blk}, {31'b0, e.blk});
    check({e.tag, ".info"},         info, e.info);
    check({e.tag, ".first_idx"},    idx,  e.idx);
    check({e.tag, ".block_cycles"}, cyc,  e.cyc);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0:       compare(e, a_block, 32'(a_info), 32'(a_idx), 32'(a_cyc));
        1:       compare(e, b_block, 32'(b_info), 32'(b_idx), 32'(b_cyc));
        2:       compare(e, c_block, 32'(c_info), 32'(c_idx), 32'(c_cyc));
        default: compare(e, d_block, 32'(d_info), 32'(d_idx), 32'(d_cyc));
      endcase
    end
  endtask

  task automatic expect_out(input string tag, input int dut, input logic blk,
                            input int info, input int idx, input int cyc);
    exp_t e;
    e.tag = tag; e.dut = dut; e.blk = blk;
    e.info = info; e.idx = idx; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic expect_zero_all(input string tag);
    for (int k = 0; k < 4; k++) expect_out(tag, k, 1'b0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    drain();
  endtask

  // Channel 1 (output stream) stalls for three cycles.
  task automatic scenario1(input string tag);
    for (int i = 0; i < 3; i++) begin
      a_axis = 2'b10;
      expect_out(tag, 0, 1'b1, 4'b0100, 1, i + 1);
      tick();
    end
    a_axis = 2'b00;
    expect_out({tag, "_rel"}, 0, 1'b0, 0, 1, 3);
    tick();
    expect_out({tag, "_idle"}, 0, 1'b0, 0, 1, 3);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    a_axis = '0; a_idle = '0; a_iblk = '0; a_clear = 1'b0;
    b_axis = '0; b_idle = '0; b_iblk = '0; b_clear = 1'b0;
    c_axis = '0; c_idle = '0; c_iblk = '0; c_clear = 1'b0;
    d_axis = '0; d_idle = '0; d_iblk = '0; d_clear = 1'b0;

    #2;
    expect_zero_all("reset");
    drain();
    @(negedge clock);
    reset = 1'b1;
    expect_zero_all("post_reset");
    tick();

    // 1: default single-cycle detection
    scenario1("s1");

    // clear beats trigger, clear in BLOCKED, re-detection next cycle
    a_axis = 2'b10; a_clear = 1'b1;
    expect_out("clr_trig", 0, 1'b0, 0, 0, 0);          tick();
    a_clear = 1'b0;
    expect_out("clr_redet", 0, 1'b1, 4'b0100, 1, 1);   tick();
    a_clear = 1'b1;
    expect_out("clr_blocked", 0, 1'b0, 0, 0, 0);       tick();
    a_clear = 1'b0;
    expect_out("clr_redet2", 0, 1'b1, 4'b0100, 1, 1);  tick();
    a_axis = 2'b00;
    expect_out("clr_rel", 0, 1'b0, 0, 1, 1);           tick();

    // 2: HOLD_CYCLES=4, short burst ignored, long burst detected on 4th edge
    for (int i = 0; i < 3; i++) begin
      b_axis = 2'b01; expect_out("s2_short", 1, 1'b0, 0, 0, 0); tick();
    end
    b_axis = 2'b00; expect_out("s2_gap", 1, 1'b0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      b_axis = 2'b01;
      if (i < 3) expect_out("s2_wait", 1, 1'b0, 0, 0, 0);
      else       expect_out("s2_block", 1, 1'b1, 4'b0010, 0, i - 2);
      tick();
    end
    b_axis = 2'b00; expect_out("s2_rel", 1, 1'b0, 0, 0, 2); tick();

    // 3: sub-instance aggregation
    c_iblk = 3'b001; c_idle = 3'b110;
    for (int i = 0; i < 2; i++) begin
      expect_out("s3_inst", 2, 1'b1, 0, 2, i + 1); tick();
    end
    c_idle = 3'b010;
    for (int i = 0; i < 2; i++) begin
      expect_out("s3_busy", 2, 1'b0, 0, 2, 2); tick();
    end
    c_iblk = '0; c_idle = '0;

    // 4+5: sticky latch, frozen info, saturating counter, clear
    d_axis = 2'b01;
    expect_out("s4_blk", 3, 1'b1, 4'b0010, 0, 1); tick();
    expect_out("s4_blk", 3, 1'b1, 4'b0010, 0, 2); tick();
    d_axis = 2'b00;
    expect_out("s4_latch", 3, 1'b1, 4'b0010, 0, 3); tick();
    for (int i = 0; i < 18; i++) begin
      expect_out("s5_sat", 3, 1'b1, 4'b0010, 0, (4 + i > 15) ? 15 : 4 + i); tick();
    end
    d_clear = 1'b1;
    expect_out("s4_clear", 3, 1'b0, 0, 0, 0); tick();
    d_clear = 1'b0;
    expect_out("s4_after", 3, 1'b0, 0, 0, 0); tick();
    // clear out of LATCHED with a live candidate resumes via SUSPECT
    d_axis = 2'b01;
    expect_out("s4b_blk", 3, 1'b1, 4'b0010, 0, 1); tick();
    d_axis = 2'b00;
    expect_out("s4b_latch", 3, 1'b1, 4'b0010, 0, 2); tick();
    d_axis = 2'b10; d_clear = 1'b1;
    expect_out("s4b_clr_cand", 3, 1'b0, 0, 0, 0); tick();
    d_clear = 1'b0;
    expect_out("s4b_reblk", 3, 1'b1, 4'b0100, 1, 1); tick();
    d_axis = 2'b00;
    expect_out("s4b_relatch", 3, 1'b1, 4'b0100, 1, 2); tick();

    // 6: async reset mid-SUSPECT (B), mid-BLOCKED (A), mid-LATCHED (D)
    b_axis = 2'b01;
    expect_out("s6_susp", 1, 1'b0, 0, 0, 2); tick();
    expect_out("s6_susp", 1, 1'b0, 0, 0, 2); tick();
    a_axis = 2'b10;
    expect_out("s6_susp", 1, 1'b0, 0, 0, 2);
    expect_out("s6_ablk", 0, 1'b1, 4'b0100, 1, 1); tick();
    #2;
    reset = 1'b0;
    a_axis = '0; b_axis = '0; d_axis = '0;
    #1;
    expect_zero_all("s6_async");
    drain();
    expect_zero_all("s6_hold");
    tick();
    @(negedge clock);
    reset = 1'b1;
    scenario1("s6_s1");
    for (int i = 0; i < 4; i++) begin
      b_axis = 2'b01;
      if (i < 3) expect_out("s6_bwait", 1, 1'b0, 0, 0, 0);
      else       expect_out("s6_bblk", 1, 1'b1, 4'b0010, 0, 1);
      expect_out("s6_dquiet", 3, 1'b0, 0, 0, 0);
      tick();
    end
    b_axis = 2'b00;
    expect_out("s6_brel", 1, 1'b0, 0, 0, 1); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
